// File: rtl/cnt_seg_scan.sv
// Four-digit multiplexed seven-segment driver for 4-bit counter values.
// Digit values are shadowed once per frame so a displayed frame never tears.
module cnt_seg_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       blank_lz,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] dp_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);

    logic [PreW-1:0] pre_q, pre_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d;
    logic [3:0]      sh_dp_q, sh_dp_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic            pre_wrap, frame_wrap, blanked;
    logic [3:0]      cur;
    logic [3:0]      lz;

    // Active-low segments, bit 6 = g down to bit 0 = a.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            4'hF: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        pre_wrap   = (pre_q == PreLast);
        frame_wrap = pre_wrap && (idx_q == 2'd3);

        pre_d = pre_wrap ? '0 : pre_q + 1'b1;
        idx_d = pre_wrap ? idx_q + 2'd1 : idx_q;

        sh0_d   = frame_wrap ? d0 : sh0_q;
        sh1_d   = frame_wrap ? d1 : sh1_q;
        sh2_d   = frame_wrap ? d2 : sh2_q;
        sh3_d   = frame_wrap ? d3 : sh3_q;
        sh_dp_d = frame_wrap ? dp_mask : sh_dp_q;

        cur = sh0_q;
        case (idx_q)
            2'd0: cur = sh0_q;
            2'd1: cur = sh1_q;
            2'd2: cur = sh2_q;
            2'd3: cur = sh3_q;
        endcase

        // lz[k]: every shadow digit from 3 down to k is zero; digit 0 always shows.
        lz[3] = (sh3_q == 4'h0);
        lz[2] = lz[3] && (sh2_q == 4'h0);
        lz[1] = lz[2] && (sh1_q == 4'h0);
        lz[0] = 1'b0;

        blanked = blank_lz && lz[idx_q];

        an_d  = 4'hF;
        seg_d = 7'h7F;
        if (en && !blanked) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = hex7(cur);
        end
        dp_d = en ? ~sh_dp_q[idx_q] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pre_q   <= '0;
            idx_q   <= 2'd0;
            sh0_q   <= 4'h0;
            sh1_q   <= 4'h0;
            sh2_q   <= 4'h0;
            sh3_q   <= 4'h0;
            sh_dp_q <= 4'h0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            sh3_q   <= sh3_d;
            sh_dp_q <= sh_dp_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_cnt_seg_scan.sv
// Directed bench for cnt_seg_scan with SCAN_DIV=4; outputs checked as {an, seg, dp}.
module tb_cnt_seg_scan;

    logic       clk = 1'b0;
    logic       clr, en, blank_lz;
    logic [3:0] d0, d1, d2, d3, dp_mask;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] Off = {4'hF, 7'h7F, 1'b1};

    cnt_seg_scan #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .blank_lz (blank_lz),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .dp_mask  (dp_mask),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     tag, obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] outv();
        return {an, seg, dp};
    endfunction

    // Edge numbers in comments count rising edges since clr was released.
    initial begin
        clr = 1'b1; en = 1'b1; blank_lz = 1'b0;
        d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0; dp_mask = 4'h0;

        step(3);
        check("reset", outv(), Off);

        clr = 1'b0;
        step(1);   // edge 1
        check("first_digit0", outv(), {4'b1110, 7'b1000000, 1'b1});
        step(3);   // edge 4
        check("digit0_last", outv(), {4'b1110, 7'b1000000, 1'b1});
        step(1);   // edge 5
        check("digit1", outv(), {4'b1101, 7'b1000000, 1'b1});
        step(4);   // edge 9
        check("digit2", outv(), {4'b1011, 7'b1000000, 1'b1});
        step(4);   // edge 13
        check("digit3", outv(), {4'b0111, 7'b1000000, 1'b1});
        step(4);   // edge 17
        check("digit0_wrap", outv(), {4'b1110, 7'b1000000, 1'b1});

        // Hex decode: captured at edge 32, shown from edge 33.
        d3 = 4'hF; d2 = 4'hA; d1 = 4'h8; d0 = 4'h1;
        step(16);  // edge 33
        check("hex_d0_1", outv(), {4'b1110, 7'b1111001, 1'b1});
        step(4);   // edge 37
        check("hex_d1_8", outv(), {4'b1101, 7'b0000000, 1'b1});
        step(4);   // edge 41
        check("hex_d2_A", outv(), {4'b1011, 7'b0001000, 1'b1});
        step(4);   // edge 45
        check("hex_d3_F", outv(), {4'b0111, 7'b0001110, 1'b1});

        // No tearing: inputs changed while idx=1 (edge 53) appear only after the wrap at edge 64.
        step(8);   // edge 53
        d0 = 4'h2; d3 = 4'hE;
        step(8);   // edge 61
        check("notear_d3", outv(), {4'b0111, 7'b0001110, 1'b1});
        step(3);   // edge 64
        check("notear_d3_last", outv(), {4'b0111, 7'b0001110, 1'b1});
        step(1);   // edge 65
        check("newframe_d0_2", outv(), {4'b1110, 7'b0100100, 1'b1});
        step(12);  // edge 77
        check("newframe_d3_E", outv(), {4'b0111, 7'b0000110, 1'b1});

        // Leading-zero blanking: value 0047 captured at edge 80.
        blank_lz = 1'b1;
        d3 = 4'h0; d2 = 4'h0; d1 = 4'h4; d0 = 4'h7;
        step(4);   // edge 81
        check("lz_d0_7", outv(), {4'b1110, 7'b1111000, 1'b1});
        step(4);   // edge 85
        check("lz_d1_4", outv(), {4'b1101, 7'b0011001, 1'b1});
        step(4);   // edge 89
        check("lz_d2_blank", outv(), Off);
        step(4);   // edge 93
        check("lz_d3_blank", outv(), Off);
        d1 = 4'h0; d0 = 4'h0;
        step(4);   // edge 97
        check("lz_zero_d0", outv(), {4'b1110, 7'b1000000, 1'b1});
        step(4);   // edge 101
        check("lz_zero_d1_blank", outv(), Off);
        step(8);   // edge 109
        check("lz_zero_d3_blank", outv(), Off);

        // Decimal point and enable: dp_mask captured at edge 112.
        blank_lz = 1'b0;
        dp_mask  = 4'b0100;
        step(4);   // edge 113
        check("dp_d0_off", outv(), {4'b1110, 7'b1000000, 1'b1});
        step(8);   // edge 121
        check("dp_d2_on", outv(), {4'b1011, 7'b1000000, 1'b0});
        step(1);   // edge 122
        en = 1'b0;
        step(1);   // edge 123
        check("en_off", outv(), Off);
        en = 1'b1;
        step(1);   // edge 124
        check("en_back_d2", outv(), {4'b1011, 7'b1000000, 1'b0});
        step(1);   // edge 125
        check("en_back_d3", outv(), {4'b0111, 7'b1000000, 1'b1});

        // Reset mid-scan at idx=2, pre=1 (edge 137); 5555 with all dps captured at edge 128.
        d3 = 4'h5; d2 = 4'h5; d1 = 4'h5; d0 = 4'h5; dp_mask = 4'hF;
        step(12);  // edge 137
        check("pre_clr_d2_5", outv(), {4'b1011, 7'b0010010, 1'b0});
        clr = 1'b1;
        step(1);
        check("clr_midscan", outv(), Off);
        clr = 1'b0;
        step(1);   // new edge 1
        check("restart_d0_zero", outv(), {4'b1110, 7'b1000000, 1'b1});
        step(4);   // new edge 5
        check("restart_d1_zero", outv(), {4'b1101, 7'b1000000, 1'b1});
        step(12);  // new edge 17
        check("restart_capture", outv(), {4'b1110, 7'b0010010, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
